// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with direct (latched) and scan (walking) modes.
// Define DECODER_ACTIVE_LOW_EN to make o_d active-low (inactive value all ones).
module decoder_nto2n_seq #(
  parameter int N     = 2,
  parameter int DWELL = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_mode,
  input  logic [N-1:0]      i_a,
  input  logic              i_a_valid,
  output logic [(1<<N)-1:0] o_d,
  output logic              o_d_valid,
  output logic              o_busy,
  output logic              o_scan_done
);

  localparam int NL = 1 << N;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DWELL - 1);
  localparam logic [N-1:0]  STEP_MAX = N'(NL - 1);

`ifdef DECODER_ACTIVE_LOW_EN
  localparam logic [NL-1:0] D_INACTIVE = {NL{1'b1}};
`else
  localparam logic [NL-1:0] D_INACTIVE = {NL{1'b0}};
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_SCAN = 2'd2
  } state_t;

  // Selected-line pattern in the polarity of this build.
  function automatic logic [NL-1:0] f_line(input logic [N-1:0] idx);
    logic [NL-1:0] v;
    v = NL'(1) << idx;
`ifdef DECODER_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  state_t          r_state;
  logic [N-1:0]    r_idx;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_steps;
  logic [NL-1:0]   r_d;
  logic            r_d_valid;
  logic            r_busy;
  logic            r_scan_done;

  state_t          w_state_nxt;
  logic [N-1:0]    w_idx_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [N-1:0]    w_steps_nxt;
  logic [NL-1:0]   w_d_nxt;
  logic            w_d_valid_nxt;
  logic            w_busy_nxt;
  logic            w_scan_done_nxt;
  logic [N-1:0]    w_idx_inc;

  assign w_idx_inc = r_idx + N'(1);

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= {N{1'b0}};
      r_cnt       <= {CW{1'b0}};
      r_steps     <= {N{1'b0}};
      r_d         <= D_INACTIVE;
      r_d_valid   <= 1'b0;
      r_busy      <= 1'b0;
      r_scan_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_steps     <= w_steps_nxt;
      r_d         <= w_d_nxt;
      r_d_valid   <= w_d_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_scan_done <= w_scan_done_nxt;
    end
  end

  // Next-state and next-output logic; a low enable overrides everything.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_cnt_nxt       = r_cnt;
    w_steps_nxt     = r_steps;
    w_d_nxt         = r_d;
    w_d_valid_nxt   = 1'b0;
    w_busy_nxt      = 1'b0;
    w_scan_done_nxt = 1'b0;

    if (!i_en) begin
      w_state_nxt = S_IDLE;
      w_d_nxt     = D_INACTIVE;
    end else begin
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (i_a_valid) begin
            w_d_nxt       = f_line(i_a);
            w_d_valid_nxt = 1'b1;
            if (i_mode) begin
              w_idx_nxt   = i_a;
              w_cnt_nxt   = {CW{1'b0}};
              w_steps_nxt = {N{1'b0}};
              w_state_nxt = S_SCAN;
              w_busy_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_HOLD;
            end
          end else begin
            w_state_nxt = r_state;
          end
        end
        S_SCAN: begin
          w_busy_nxt = 1'b1;
          if (r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + CW'(1);
          end else if (r_steps != STEP_MAX) begin
            w_cnt_nxt     = {CW{1'b0}};
            w_steps_nxt   = r_steps + N'(1);
            w_idx_nxt     = w_idx_inc;
            w_d_nxt       = f_line(w_idx_inc);
            w_d_valid_nxt = 1'b1;
          end else begin
            // Every line has had its dwell: finish and report.
            w_state_nxt     = S_IDLE;
            w_d_nxt         = D_INACTIVE;
            w_busy_nxt      = 1'b0;
            w_scan_done_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_d_nxt     = D_INACTIVE;
        end
      endcase
    end
  end

  assign o_d         = r_d;
  assign o_d_valid   = r_d_valid;
  assign o_busy      = r_busy;
  assign o_scan_done = r_scan_done;

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Directed self-checking bench for decoder_nto2n_seq (N=2, DWELL=3).
// Expected line patterns follow DECODER_ACTIVE_LOW_EN if the build defines it.
module tb_decoder_nto2n_seq;

  localparam int N     = 2;
  localparam int DWELL = 3;
  localparam int NL    = 1 << N;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          mode;
  logic [N-1:0]  a;
  logic          a_valid;
  logic [NL-1:0] d;
  logic          d_valid;
  logic          busy;
  logic          scan_done;

  int n_assert;
  int n_fail;
  int dv_cnt;
  int busy_cnt;

  decoder_nto2n_seq #(.N(N), .DWELL(DWELL)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_mode      (mode),
    .i_a         (a),
    .i_a_valid   (a_valid),
    .o_d         (d),
    .o_d_valid   (d_valid),
    .o_busy      (busy),
    .o_scan_done (scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NL-1:0] line_exp(input int idx);
    logic [NL-1:0] v;
    v = 4'b0001 << idx;
`ifdef DECODER_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  function automatic logic [NL-1:0] idle_exp();
`ifdef DECODER_ACTIVE_LOW_EN
    return 4'b1111;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    mode     = 1'b0;
    a        = 2'd0;
    a_valid  = 1'b0;
    #3;
    check("reset_d", 32'(d), 32'(idle_exp()));
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(scan_done), 32'd0);
    check("reset_dv", 32'(d_valid), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    en    = 1'b1;
    step();
    check("idle_d", 32'(d), 32'(idle_exp()));

    // Direct mode, back-to-back strobes a=0..3
    for (int i = 0; i < NL; i++) begin
      a       = 2'(i);
      a_valid = 1'b1;
      mode    = 1'b0;
      step();
      check($sformatf("direct_d_%0d", i), 32'(d), 32'(line_exp(i)));
      check($sformatf("direct_dv_%0d", i), 32'(d_valid), 32'd1);
    end
    a_valid = 1'b0;
    step();
    check("direct_hold_dv", 32'(d_valid), 32'd0);
    check("direct_hold_d", 32'(d), 32'(line_exp(3)));

    // Direct a=2, hold for 5 cycles, then disable
    a       = 2'd2;
    a_valid = 1'b1;
    step();
    check("d2_d", 32'(d), 32'(line_exp(2)));
    a_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("hold_d_%0d", i), 32'(d), 32'(line_exp(2)));
      check($sformatf("hold_dv_%0d", i), 32'(d_valid), 32'd0);
    end
    en = 1'b0;
    step();
    check("en_off_d", 32'(d), 32'(idle_exp()));
    check("en_off_busy", 32'(busy), 32'd0);
    en = 1'b1;
    step();

    // Scan from a=2 with an ignored strobe in the middle
    a       = 2'd2;
    mode    = 1'b1;
    a_valid = 1'b1;
    step();
    a_valid  = 1'b0;
    dv_cnt   = 0;
    busy_cnt = 0;
    for (int c = 0; c < NL * DWELL; c++) begin
      check($sformatf("scan_d_%0d", c), 32'(d), 32'(line_exp((2 + c / DWELL) % NL)));
      check($sformatf("scan_done_lo_%0d", c), 32'(scan_done), 32'd0);
      if (d_valid) dv_cnt++;
      if (busy) busy_cnt++;
      if (c == 1) begin
        a_valid = 1'b1;
        a       = 2'd0;
        mode    = 1'b0;
      end else begin
        a_valid = 1'b0;
      end
      step();
    end
    check("scan_end_d", 32'(d), 32'(idle_exp()));
    check("scan_end_busy", 32'(busy), 32'd0);
    check("scan_end_done", 32'(scan_done), 32'd1);
    check("scan_dv_pulses", 32'(dv_cnt), 32'd4);
    check("scan_busy_cycles", 32'(busy_cnt), 32'd12);
    step();
    check("scan_done_pulse", 32'(scan_done), 32'd0);

    // Scan abort with en=0 during the second dwell
    a       = 2'd0;
    mode    = 1'b1;
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    step();
    step();
    step();
    step();
    check("abort_pre_d", 32'(d), 32'(line_exp(1)));
    check("abort_pre_busy", 32'(busy), 32'd1);
    en = 1'b0;
    step();
    check("abort_d", 32'(d), 32'(idle_exp()));
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(scan_done), 32'd0);
    en = 1'b1;
    step();
    check("abort_after_done", 32'(scan_done), 32'd0);
    check("abort_after_d", 32'(d), 32'(idle_exp()));

    // Asynchronous reset mid-scan
    a       = 2'd1;
    mode    = 1'b1;
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    step();
    check("rst_pre_d", 32'(d), 32'(line_exp(1)));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_d", 32'(d), 32'(idle_exp()));
    check("rst_async_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("rst_after_d", 32'(d), 32'(idle_exp()));
    check("rst_after_done", 32'(scan_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
